board_scanout: RTL and testbench

- Reader side of the game board cell store. On each `start` pulse it walks every cell in raster order through a 1-cycle-latency read port.
- Each cell is decoded and streamed out on a valid/ready interface to the display/render path.
- Also builds a per-row "line full" bitmap, which the game FSM consumes for line-clear decisions.

---
 rtl/board_scanout.sv | 141 ++++++++++++++
 tb/tb_board_scanout.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/board_scanout.sv
// Frame scanner for the game board: raster-order reads through a 1-cycle read
// port, decoded beats out over valid/ready, and a per-row "settled" bitmap.
module board_scanout #(
   parameter int ROWS = 30,
   parameter int COLS = 10,
   parameter int RW   = 5,
   parameter int CW   = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            rd_en,
   output logic [RW-1:0]   rd_row,
   output logic [CW-1:0]   rd_col,
   input  logic [3:0]      rd_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [RW-1:0]   out_row,
   output logic [CW-1:0]   out_col,
   output logic            out_occ,
   output logic            out_active,
   output logic [1:0]      out_style,
   output logic            out_last,
   output logic            busy,
   output logic            frame_done,
   output logic [ROWS-1:0] full_rows
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   typedef struct packed {
      logic [RW-1:0] row;
      logic [CW-1:0] col;
      logic          occ;
      logic          active;
      logic [1:0]    style;
      logic          last;
   } beat_t;

   state_t          state;
   beat_t           fifo [2];
   logic [1:0]      cnt;
   logic            wptr, rptr;
   logic            dvalid;
   logic [RW-1:0]   d_row;
   logic [CW-1:0]   d_col;
   logic            run_and;
   logic [ROWS-1:0] acc;

   logic            push, pop, row_and, last_addr;
   logic [1:0]      cnt_n;
   logic [2:0]      pending;
   beat_t           d_beat;

   assign push      = dvalid;
   assign out_valid = (cnt != 2'd0);
   assign pop       = out_valid & out_ready;
   assign cnt_n     = cnt + {1'b0, push} - {1'b0, pop};
   assign last_addr = (rd_row == RW'(ROWS-1)) && (rd_col == CW'(COLS-1));

   // Credit counts the beat leaving this cycle, so a held-high out_ready
   // sustains one read per clock with only two FIFO entries.
   assign pending = {1'b0, cnt} + {2'b0, dvalid} - {2'b0, pop};
   assign rd_en   = (state == SCAN) && (pending < 3'd2);

   assign row_and = ((d_col == '0) ? 1'b1 : run_and) & rd_data[0];

   always_comb begin
      d_beat        = '0;
      d_beat.row    = d_row;
      d_beat.col    = d_col;
      d_beat.occ    = rd_data[0] | rd_data[1];
      d_beat.active = rd_data[1];
      d_beat.style  = d_beat.occ ? rd_data[3:2] : 2'b00;
      d_beat.last   = (d_row == RW'(ROWS-1)) && (d_col == CW'(COLS-1));
   end

   assign {out_row, out_col, out_occ, out_active, out_style, out_last} = fifo[rptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         rd_row     <= '0;
         rd_col     <= '0;
         dvalid     <= 1'b0;
         d_row      <= '0;
         d_col      <= '0;
         cnt        <= '0;
         wptr       <= 1'b0;
         rptr       <= 1'b0;
         fifo[0]    <= '0;
         fifo[1]    <= '0;
         run_and    <= 1'b0;
         acc        <= '0;
         full_rows  <= '0;
      end else begin
         frame_done <= 1'b0;
         dvalid     <= rd_en;
         cnt        <= cnt_n;
         if (rd_en) begin
            d_row <= rd_row;
            d_col <= rd_col;
            if (rd_col == CW'(COLS-1)) begin
               rd_col <= '0;
               rd_row <= (rd_row == RW'(ROWS-1)) ? '0 : rd_row + 1'b1;
            end else begin
               rd_col <= rd_col + 1'b1;
            end
         end
         if (push) begin
            fifo[wptr] <= d_beat;
            wptr       <= ~wptr;
            run_and    <= row_and;
            if (d_col == CW'(COLS-1)) acc[d_row] <= row_and;
         end
         if (pop) rptr <= ~rptr;

         case (state)
            // A start coincident with frame_done belongs to the finished frame.
            IDLE: if (start && !frame_done) begin
               state  <= SCAN;
               busy   <= 1'b1;
               rd_row <= '0;
               rd_col <= '0;
               acc    <= '0;
            end
            SCAN: if (rd_en && last_addr) state <= DRAIN;
            DRAIN: if (cnt_n == 2'd0 && !dvalid) begin
               full_rows  <= acc;
               frame_done <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_board_scanout.sv
// Randomized bench for board_scanout: board memory model, raster scoreboard,
// handshake/stall and read-credit monitors, frame timing and full-row checks.
module tb_board_scanout;
   localparam int ROWS = 30;
   localparam int COLS = 10;
   localparam int RW   = 5;
   localparam int CW   = 4;

   logic            clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b1;
   logic [3:0]      rd_data = 4'd0;
   logic            rd_en, out_valid, out_occ, out_active, out_last, busy, frame_done;
   logic [RW-1:0]   rd_row, out_row;
   logic [CW-1:0]   rd_col, out_col;
   logic [1:0]      out_style;
   logic [ROWS-1:0] full_rows;

   board_scanout #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_row(out_row), .out_col(out_col), .out_occ(out_occ),
      .out_active(out_active), .out_style(out_style), .out_last(out_last),
      .busy(busy), .frame_done(frame_done), .full_rows(full_rows)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [3:0] brd [ROWS][COLS];
   always @(posedge clk) rd_data <= rd_en ? brd[rd_row][rd_col] : 4'($urandom);

   int checks = 0, errors = 0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: one beat per cell in raster order, decoded from the cell rules.
   function automatic logic [13:0] beat_of(input int r, input int c, input logic [3:0] d);
      logic occ;
      occ = d[0] | d[1];
      return {RW'(r), CW'(c), occ, d[1], (occ ? d[3:2] : 2'b00),
              1'((r == ROWS-1) && (c == COLS-1))};
   endfunction

   logic [13:0]     exp_q [$];
   logic [ROWS-1:0] exp_full;
   int  beats, fd_count, fd_cyc, first_vcyc, issued, accepted, rd_idx;
   bit  stall_prev;
   logic [13:0] prev_b, cur_b;
   int  rmode = 0;

   initial forever begin
      @(posedge clk); #1;
      case (rmode)
         0:       out_ready = 1'b1;
         1:       out_ready = (cyc % 3 == 0);
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   always @(negedge clk) begin
      if (!reset) begin
         cur_b = {out_row, out_col, out_occ, out_active, out_style, out_last};
         if (out_valid && first_vcyc < 0) first_vcyc = cyc;
         if (stall_prev) chk("stall_hold", {out_valid, cur_b}, {1'b1, prev_b});
         if (rd_en) begin
            chk("rd_addr", {rd_row, rd_col}, {RW'(rd_idx / COLS), CW'(rd_idx % COLS)});
            rd_idx++;
            issued++;
         end
         if (out_valid && out_ready) begin
            accepted++;
            beats++;
            if (exp_q.size() == 0) chk("extra_beat", 1, 0);
            else chk("beat", cur_b, exp_q.pop_front());
         end
         if (rd_en) chk("rd_budget", 1'(issued - accepted <= 2), 1);
         stall_prev = out_valid && !out_ready;
         prev_b     = cur_b;
         if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
         end
      end
   end

   task automatic fill_random();
      for (int r = 0; r < ROWS; r++) begin
         bit make_full = ($urandom_range(0, 2) == 0);
         for (int c = 0; c < COLS; c++) begin
            brd[r][c] = 4'($urandom);
            if (make_full) brd[r][c][0] = 1'b1;
         end
      end
   endtask

   task automatic launch(output int t0);
      exp_q.delete();
      exp_full = '0;
      for (int r = 0; r < ROWS; r++) begin
         bit all_set = 1'b1;
         for (int c = 0; c < COLS; c++) begin
            exp_q.push_back(beat_of(r, c, brd[r][c]));
            if (!brd[r][c][0]) all_set = 1'b0;
         end
         exp_full[r] = all_set;
      end
      beats = 0; fd_count = 0; first_vcyc = -1; fd_cyc = -1;
      issued = 0; accepted = 0; rd_idx = 0; stall_prev = 1'b0;
      @(posedge clk); #1 start = 1'b1;
      t0 = cyc + 1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic finish_frame(input int t0, input int mode, input int restart_at, input bit start_at_fd);
      bit done = 1'b0;
      for (int i = 0; i < 4000 && !done; i++) begin
         @(posedge clk); #1;
         start = ((cyc - t0) == restart_at - 1);
         if (frame_done) begin
            done = 1'b1;
            if (start_at_fd) start = 1'b1;
         end
      end
      if (!done) chk("timeout", 0, 1);
      @(posedge clk); #1 start = 1'b0;
      if (start_at_fd) chk("fd_start_ignored", {busy, rd_en}, 2'b00);
      repeat (4) @(posedge clk);
      #1;
      chk("first_valid", first_vcyc - t0, 2);
      if (mode == 0) chk("fd_latency", fd_cyc - t0, ROWS*COLS + 2);
      chk("beat_count", beats, ROWS*COLS);
      chk("fd_count", fd_count, 1);
      chk("full_rows", full_rows, exp_full);
      chk("busy_idle", busy, 0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk(tag, {rd_en, rd_row, rd_col, out_valid, out_row, out_col, out_occ,
                out_active, out_style, out_last, busy, frame_done}, 0);
      chk({tag, "_full"}, full_rows, 0);
   endtask

   initial begin
      int t0, t1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) brd[r][c] = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_state("reset_init");
      reset = 1'b0;

      // Empty board, no back-pressure.
      rmode = 0;
      launch(t0);
      finish_frame(t0, 0, -5, 1'b0);

      // Bottom row settled with style 3.
      for (int c = 0; c < COLS; c++) brd[ROWS-1][c] = 4'b1101;
      launch(t0);
      finish_frame(t0, 0, -5, 1'b0);

      // Row 5 nearly settled but col 4 only holds the active piece.
      fill_random();
      for (int c = 0; c < COLS; c++) brd[5][c] = 4'b0001;
      brd[5][4] = 4'b0010;
      rmode = 1;
      launch(t0);
      finish_frame(t0, 1, -5, 1'b0);

      // Random stalls, start mid-scan and start coincident with frame_done.
      fill_random();
      rmode = 2;
      launch(t0);
      finish_frame(t0, 2, 100, 1'b1);

      // Reset mid-scan, then a fresh scan.
      fill_random();
      for (int c = 0; c < COLS; c++) begin
         brd[3][c][0]  = 1'b1;
         brd[17][c][0] = 1'b1;
      end
      rmode = 0;
      launch(t0);
      for (int i = 0; i < 100 && (cyc - t0) < 50; i++) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      stall_prev = 1'b0;
      chk_reset_state("reset_mid");
      for (int i = 0; i < 100 && (cyc - t0) < 58; i++) begin
         @(posedge clk); #1;
      end
      launch(t1);
      finish_frame(t1, 0, -5, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
